ddr_burst_rd_master: RTL
========================

// Module: ddr_burst_rd_master
// PURPOSE
// Avalon-MM burst read master. Fetches a contiguous region of DDR and delivers it to the reorg stage as a 64-bit valid/ready stream.
// Splits a request (base byte address, length in 64-bit words) into bursts of at most BURST_LEN beats.
// Bursts are credit-limited by free space in an internal show-ahead FIFO.
// PARAMETERS
// BURST_LEN   16   max beats per burst (1..16; avm_burstcount is 5 bits)
// FIFO_DEPTH  64   output FIFO depth in 64-bit words (power of 2, >= BURST_LEN)
// PORTS
// exclk                input   1   system clock
// rst_n                input   1   async active-low reset
// start                input   1   1-cycle request strobe, sampled only when busy=0
// base_addr            input   32  byte address of first word, 8-byte aligned
// len_words            input   16  number of 64-bit words to fetch
// busy                 output  1   high from accepted start until done
// done                 output  1   1-cycle pulse: last word written into FIFO
// avm_waitrequest      input   1   slave stall
// avm_read             output  1   read command
// avm_address          output  32  burst start byte address
// avm_burstcount       output  5   beats in this burst
// avm_byteenable       output  8   constant 8'hFF
// avm_readdata         input   64  return data
// avm_readdatavalid    input   1   return data strobe
// out_valid            output  1   FIFO not empty
// out_data             output  64  FIFO head word
// out_ready            input   1   consumer accepts head when out_valid=1
// BEHAVIOUR
// - Reset values: busy=0, done=0, avm_read=0, avm_address=0, avm_burstcount=0, out_valid=0. FIFO is emptied; all counters and the FSM clear.
// - avm_byteenable is always 8'hFF, including during reset.
// - FSM states: IDLE, ISSUE, WAIT_RX.
//   - IDLE: start & len_words!=0 -> latch addr/remaining=len, busy=1 -> ISSUE.
//   - IDLE: start & len_words==0 -> done=1 on the next cycle; busy stays 0; no bus traffic.
//   - ISSUE: when remaining!=0 and credit allows, drive avm_read=1 with avm_address=cur_addr and avm_burstcount=min(remaining,BURST_LEN).
//   - ISSUE: read, address and burstcount hold stable while avm_waitrequest=1.
//   - ISSUE: on the accept cycle (read & !waitrequest): cur_addr += burstcount*8; remaining -= burstcount; outstanding += burstcount.
//   - ISSUE: drop avm_read the next cycle unless another burst qualifies; back-to-back bursts are allowed.
//   - ISSUE: remaining==0 after accept -> WAIT_RX.
//   - WAIT_RX: when received==len -> done=1 for one cycle, busy=0 -> IDLE.
// - Credit rule: issue only if fifo_count + outstanding + burstcount <= FIFO_DEPTH. The FIFO never overflows.
// - Every avm_readdatavalid beat pushes into the FIFO and decrements outstanding.
// - avm_readdatavalid outside a request is a protocol error. It is still pushed, and an SVA flags it.
// - An accept and a returning beat in the same cycle update outstanding by +burstcount-1.
// - FIFO is show-ahead: out_data is valid with out_valid, no read latency.
//   - Pop when out_valid & out_ready.
//   - Push and pop in the same cycle leave the count unchanged, including when the FIFO is full.
// - done pulses when the last word enters the FIFO, not when it is drained. A new start is accepted the cycle after done.
// - start while busy=1 is ignored.
// - Address arithmetic is 32-bit, wrap at 2^32 is not detected. Bursts are not split at page boundaries.
// - rst_n asserted mid-burst aborts immediately. Beats in flight after reset release must not be issued by the slave; the system resets the slave together with this block.
// - Throughput: with waitrequest=0 and out_ready=1, the master sustains 1 beat/cycle once the FIFO holds one burst of credit.
// TESTING
// - len=40, BURST_LEN=16, base=0x1000, no stalls -> bursts (0x1000,16), (0x1080,16), (0x1100,8); 40 words out in order; done once.
// - len=0 start -> done pulse 1 cycle later; avm_read never asserted; busy stays 0.
// - waitrequest high 5 cycles on first command -> address/burstcount/read stable through stall; data matches DDR model.
// - out_ready=0 throughout, len=200, FIFO_DEPTH=64 -> at most 64 words requested, no more bursts after that; releasing out_ready resumes; all 200 delivered.
// - Random out_ready and random readdatavalid gaps, len=1000 -> FIFO never overflows (SVA); stream equals reference sequence.
// - rst_n pulled low mid-transfer -> all outputs at reset values next edge; new start after release runs a clean transfer.

Source files
------------

// File: rtl/ddr_burst_rd_master.sv
// ddr_burst_rd_master
// Avalon-MM burst read master. Fetches len_words contiguous 64-bit words
// starting at base_addr and streams them out through a show-ahead FIFO.
// A request is split into bursts of at most BURST_LEN beats. Each burst is
// issued only when the FIFO has room for every beat still in flight.
//
// Ports
//   exclk, rst_n            clock, asynchronous active-low reset
//   start, base_addr,       request strobe (sampled while busy=0), byte
//   len_words               address of first word, length in 64-bit words
//   busy, done              transfer in progress / last word entered FIFO
//   avm_*                   Avalon-MM read master (burst)
//   out_valid, out_data,    show-ahead output stream; a word is popped
//   out_ready               when out_valid & out_ready
module ddr_burst_rd_master #(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic        exclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] len_words,
  output logic        busy,
  output logic        done,
  input  logic        avm_waitrequest,
  output logic        avm_read,
  output logic [31:0] avm_address,
  output logic [4:0]  avm_burstcount,
  output logic [7:0]  avm_byteenable,
  input  logic [63:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        out_valid,
  output logic [63:0] out_data,
  input  logic        out_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RX} state_t;

  state_t        state, state_nxt;
  logic [31:0]   cur_addr, addr_nxt;
  logic [15:0]   remaining, rem_nxt;
  logic [15:0]   len_q;
  logic [15:0]   received, rx_nxt;
  logic [CW-1:0] outstanding, out_nxt;
  logic [CW-1:0] fifo_count, cnt_nxt;
  logic [4:0]    bc_nxt;
  logic [31:0]   credit;
  logic          accept, push, pop, issue_ok, done_nxt;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign accept         = avm_read & ~avm_waitrequest;
  assign push           = avm_readdatavalid;
  assign pop            = out_valid & out_ready;
  assign avm_byteenable = 8'hFF;
  assign busy           = (state != IDLE);
  assign out_valid      = (fifo_count != '0);
  assign out_data       = mem[rd_ptr];

  assign cnt_nxt = fifo_count + CW'(push) - CW'(pop);
  assign out_nxt = outstanding + (accept ? CW'(avm_burstcount) : '0) - CW'(push);

  // The next command is qualified against next-cycle occupancy and
  // in-flight beats; that sum can only shrink while a command waits, so a
  // held command never breaks the credit bound.
  always_comb begin
    state_nxt = state;
    addr_nxt  = cur_addr;
    rem_nxt   = remaining;
    rx_nxt    = received + 16'(push);
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        rx_nxt = '0;
        if (start) begin
          if (len_words != '0) begin
            state_nxt = ISSUE;
            addr_nxt  = base_addr;
            rem_nxt   = len_words;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (accept) begin
          addr_nxt = cur_addr + {24'b0, avm_burstcount, 3'b000};
          rem_nxt  = remaining - 16'(avm_burstcount);
          if (rem_nxt == '0) state_nxt = WAIT_RX;
        end
      end
      WAIT_RX: begin
        if (rx_nxt == len_q) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    bc_nxt   = (rem_nxt >= 16'(BURST_LEN)) ? 5'(BURST_LEN) : rem_nxt[4:0];
    credit   = 32'(cnt_nxt) + 32'(out_nxt) + 32'(bc_nxt);
    issue_ok = (state_nxt == ISSUE) && (rem_nxt != '0) && (credit <= FIFO_DEPTH);
  end

  always_ff @(posedge exclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge exclk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr       <= '0;
      remaining      <= '0;
      len_q          <= '0;
      received       <= '0;
      outstanding    <= '0;
      done           <= 1'b0;
      avm_read       <= 1'b0;
      avm_address    <= '0;
      avm_burstcount <= '0;
    end else begin
      cur_addr    <= addr_nxt;
      remaining   <= rem_nxt;
      received    <= rx_nxt;
      outstanding <= out_nxt;
      done        <= done_nxt;
      if (state == IDLE && start && len_words != '0) len_q <= len_words;
      if (!(avm_read && avm_waitrequest)) begin
        avm_read       <= issue_ok;
        avm_address    <= addr_nxt;
        avm_burstcount <= issue_ok ? bc_nxt : '0;
      end
    end
  end

  always_ff @(posedge exclk) begin
    if (push) mem[wr_ptr] <= avm_readdata;
  end

  always_ff @(posedge exclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= cnt_nxt;
    end
  end

  a_no_overflow: assert property (@(posedge exclk) disable iff (!rst_n)
    (push && !pop) |-> (fifo_count < CW'(FIFO_DEPTH)))
    else $error("fifo overflow");

  a_rdv_in_request: assert property (@(posedge exclk) disable iff (!rst_n)
    push |-> (state != IDLE))
    else $error("readdatavalid outside a request");

  a_cmd_hold: assert property (@(posedge exclk) disable iff (!rst_n)
    (avm_read && avm_waitrequest) |=>
      (avm_read && $stable(avm_address) && $stable(avm_burstcount)))
    else $error("command changed during waitrequest");

endmodule
